// File: rtl/leaf_stream_bridge.sv
// leaf_stream_bridge: leaf-side bridge between one BFT network port and
// NUM_IN_PORTS user egress streams / NUM_OUT_PORTS user ingress streams.
// Ingress packets are demultiplexed by port into per-output FWFT FIFOs
// (port 0 carries config writes). Egress round-robins the user streams into
// packets whose destination comes from the runtime config table.
// Optional macro LEAF_BRIDGE_STATS_EN adds drop_cnt / tx_cnt outputs.
//
// Handshake: every user stream is ap_vld/ap_ack. A word transfers in any
// cycle where vld and ack are both 1. vld never depends on ack. ack on the
// egress side is combinational from vld. The BFT side has no backpressure
// other than resend, which freezes the registered dout for re-presentation.
module leaf_stream_bridge #(
  parameter int PAYLOAD_BITS   = 32,
  parameter int NUM_LEAF_BITS  = 5,
  parameter int NUM_PORT_BITS  = 4,
  parameter int NUM_ADDR_BITS  = 7,
  parameter int NUM_IN_PORTS   = 2,
  parameter int NUM_OUT_PORTS  = 2,
  parameter int FIFO_ADDR_BITS = 2,
  localparam int PACKET_BITS   = 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [PACKET_BITS-1:0]                din_leaf_bft2interface,
  output logic [PACKET_BITS-1:0]                dout_leaf_interface2bft,
  input  logic                                  resend,
  input  logic                                  ap_start,
  input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  din_leaf_user2interface,
  input  logic [NUM_IN_PORTS-1:0]               vld_user2interface,
  output logic [NUM_IN_PORTS-1:0]               ack_interface2user,
  output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] dout_leaf_interface2user,
  output logic [NUM_OUT_PORTS-1:0]              vld_interface2user,
  input  logic [NUM_OUT_PORTS-1:0]              ack_user2interface
`ifdef LEAF_BRIDGE_STATS_EN
  ,
  output logic [15:0]                           drop_cnt,
  output logic [15:0]                           tx_cnt
`endif
);

  localparam int DEPTH = 2 ** FIFO_ADDR_BITS;
  localparam int CNT_W = FIFO_ADDR_BITS + 1;
  localparam int CFG_W = NUM_LEAF_BITS + NUM_PORT_BITS;
  localparam int PTR_W = (NUM_IN_PORTS > 1) ? $clog2(NUM_IN_PORTS) : 1;

  // ---------------- ingress packet fields ----------------
  logic                      pkt_vld;
  logic [NUM_LEAF_BITS-1:0]  pkt_leaf;
  logic [NUM_PORT_BITS-1:0]  pkt_port;
  logic [NUM_ADDR_BITS-1:0]  pkt_addr;
  logic [PAYLOAD_BITS-1:0]   pkt_payload;

  assign {pkt_vld, pkt_leaf, pkt_port, pkt_addr, pkt_payload} = din_leaf_bft2interface;

  // ---------------- ingress FIFO state ----------------
  logic [PAYLOAD_BITS-1:0]   mem_q    [NUM_OUT_PORTS][DEPTH];
  logic [FIFO_ADDR_BITS-1:0] wr_ptr_q [NUM_OUT_PORTS];
  logic [FIFO_ADDR_BITS-1:0] rd_ptr_q [NUM_OUT_PORTS];
  logic [CNT_W-1:0]          count_q  [NUM_OUT_PORTS];

  logic [NUM_OUT_PORTS-1:0]  full;
  logic [NUM_OUT_PORTS-1:0]  push;
  logic [NUM_OUT_PORTS-1:0]  pop;
  logic                      cfg_wr;
  logic                      drop;

  // ---------------- egress state ----------------
  logic                      start_q;
  logic [CFG_W-1:0]          cfg_q      [NUM_IN_PORTS];
  logic [NUM_IN_PORTS-1:0]   cfg_valid_q;
  logic [NUM_ADDR_BITS-1:0]  seq_q      [NUM_IN_PORTS];
  logic [PTR_W-1:0]          ptr_q, ptr_d;
  logic [PACKET_BITS-1:0]    dout_q, dout_d;

  logic [NUM_IN_PORTS-1:0]   elig;
  logic                      grant_found;
  logic [PTR_W-1:0]          grant_idx;
  logic [CFG_W-1:0]          grant_cfg;
  logic [NUM_ADDR_BITS-1:0]  grant_seq;
  logic [PAYLOAD_BITS-1:0]   grant_data;

  logic                      unused_sink;
  assign unused_sink = ^{pkt_leaf, drop};

  // Decode the incoming packet: config write, FIFO push, or drop. Full is the
  // pre-pop occupancy, so a push into a full FIFO is dropped even on a pop.
  always_comb begin
    cfg_wr = 1'b0;
    push   = '0;
    drop   = 1'b0;
    for (int j = 0; j < NUM_OUT_PORTS; j++) begin
      full[j] = (count_q[j] == CNT_W'(DEPTH));
      pop[j]  = (count_q[j] != '0) && ack_user2interface[j];
    end
    if (pkt_vld) begin
      if (pkt_port == '0) begin
        cfg_wr = (int'(pkt_addr) < NUM_IN_PORTS);
      end else if (int'(pkt_port) > NUM_OUT_PORTS) begin
        drop = 1'b1;
      end else begin
        for (int j = 0; j < NUM_OUT_PORTS; j++) begin
          if (int'(pkt_port) == j + 1) begin
            if (full[j]) drop = 1'b1;
            else         push[j] = 1'b1;
          end
        end
      end
    end
  end

  // FIFO storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    for (int j = 0; j < NUM_OUT_PORTS; j++) begin
      if (push[j]) mem_q[j][wr_ptr_q[j]] <= pkt_payload;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < NUM_OUT_PORTS; j++) begin
        wr_ptr_q[j] <= '0;
        rd_ptr_q[j] <= '0;
        count_q[j]  <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_OUT_PORTS; j++) begin
        if (push[j]) wr_ptr_q[j] <= wr_ptr_q[j] + 1'b1;
        if (pop[j])  rd_ptr_q[j] <= rd_ptr_q[j] + 1'b1;
        count_q[j] <= count_q[j] + CNT_W'(push[j]) - CNT_W'(pop[j]);
      end
    end
  end

  // First-word-fall-through user outputs: valid whenever non-empty, head on data.
  always_comb begin
    vld_interface2user       = '0;
    dout_leaf_interface2user = '0;
    for (int j = 0; j < NUM_OUT_PORTS; j++) begin
      vld_interface2user[j] = (count_q[j] != '0);
      dout_leaf_interface2user[j*PAYLOAD_BITS +: PAYLOAD_BITS] = mem_q[j][rd_ptr_q[j]];
    end
  end

  // Round-robin grant from ptr_q among eligible streams; resend blocks grants.
  always_comb begin
    elig        = start_q ? (vld_user2interface & cfg_valid_q) : '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    if (!resend) begin
      for (int i = 0; i < NUM_IN_PORTS; i++) begin
        if (!grant_found && elig[(int'(ptr_q) + i) % NUM_IN_PORTS]) begin
          grant_found = 1'b1;
          grant_idx   = PTR_W'((int'(ptr_q) + i) % NUM_IN_PORTS);
        end
      end
    end
  end

  // Select the granted stream's fields and build next dout / pointer / acks.
  always_comb begin
    grant_cfg          = '0;
    grant_seq          = '0;
    grant_data         = '0;
    ack_interface2user = '0;
    for (int k = 0; k < NUM_IN_PORTS; k++) begin
      if (grant_found && int'(grant_idx) == k) begin
        grant_cfg             = cfg_q[k];
        grant_seq             = seq_q[k];
        grant_data            = din_leaf_user2interface[k*PAYLOAD_BITS +: PAYLOAD_BITS];
        ack_interface2user[k] = 1'b1;
      end
    end
    dout_d = dout_q;
    ptr_d  = ptr_q;
    if (!resend) begin
      dout_d = grant_found ? {1'b1, grant_cfg, grant_seq, grant_data} : '0;
    end
    if (grant_found) begin
      ptr_d = (int'(grant_idx) == NUM_IN_PORTS - 1) ? '0 : grant_idx + 1'b1;
    end
  end

  // Egress registers: start latch, config table, sequence counters, pointer, dout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_q     <= 1'b0;
      cfg_valid_q <= '0;
      ptr_q       <= '0;
      dout_q      <= '0;
      for (int k = 0; k < NUM_IN_PORTS; k++) begin
        cfg_q[k] <= '0;
        seq_q[k] <= '0;
      end
    end else begin
      if (ap_start) start_q <= 1'b1;
      ptr_q  <= ptr_d;
      dout_q <= dout_d;
      for (int k = 0; k < NUM_IN_PORTS; k++) begin
        if (cfg_wr && int'(pkt_addr) == k) begin
          cfg_q[k]       <= pkt_payload[CFG_W-1:0];
          cfg_valid_q[k] <= 1'b1;
        end
        if (grant_found && int'(grant_idx) == k) seq_q[k] <= seq_q[k] + 1'b1;
      end
    end
  end

  assign dout_leaf_interface2bft = dout_q;

`ifdef LEAF_BRIDGE_STATS_EN
  logic [15:0] drop_cnt_q;
  logic [15:0] tx_cnt_q;

  // Saturating statistics counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt_q <= '0;
      tx_cnt_q   <= '0;
    end else begin
      if (drop && drop_cnt_q != 16'hFFFF)      drop_cnt_q <= drop_cnt_q + 16'd1;
      if (grant_found && tx_cnt_q != 16'hFFFF) tx_cnt_q   <= tx_cnt_q + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
  assign tx_cnt   = tx_cnt_q;
`endif

endmodule
